// File: rtl/can_rx_frame_if.sv
// can_rx_frame_if: the bus line seen by the CAN receive decoder plus the
// decoded-frame outputs it presents.
//   master : decoder side (listens to CAN, drives payload and strobes)
//   slave  : bus / consumer side (drives CAN, reads payload and strobes)
interface can_rx_frame_if #(
    parameter int WIDTH = 128
);
    logic             CAN;
    logic [WIDTH-1:0] DOUT;
    logic             rx_ready;
    logic             rx_error;
    logic             busy;

    modport master (
        input  CAN,
        output DOUT, rx_ready, rx_error, busy
    );

    modport slave (
        output CAN,
        input  DOUT, rx_ready, rx_error, busy
    );
endinterface

// File: rtl/can_rx_frame.sv
// can_rx_frame: passive CAN-style frame decoder.
// Synchronises the open-drain bus line (dominant = 0), recovers bit timing
// from falling edges, destuffs SOF..DATA(..CRC) and checks a 7-bit recessive
// EOF. A good frame updates DOUT with a one-cycle rx_ready; stuff, form or
// CRC errors give a one-cycle rx_error and leave DOUT alone.
// Optional feature macro: CAN_RX_CRC15_EN adds a stuffed 15-bit CAN CRC field
// after DATA; without it DATA is followed directly by EOF.
module can_rx_frame #(
    parameter int WIDTH     = 128,
    parameter int QUANTA    = 39,
    parameter int SP        = 30,
    parameter int IDLE_BITS = 11
) (
    input  logic           GCLK,
    input  logic           RES,
    can_rx_frame_if.master bus
);
    localparam int QW = $clog2(QUANTA);
    localparam int BW = $clog2(WIDTH + 16);
    localparam int IW = $clog2(IDLE_BITS + 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        SOF,
        DATA,
`ifdef CAN_RX_CRC15_EN
        CRC,
`endif
        EOF
    } state_t;

    logic             can_meta_reg, can_sync_reg, can_prev_reg;
    logic [QW-1:0]    qc_reg, qc_next;
    state_t           state_reg, state_next, field_next;
    logic [IW-1:0]    idle_cnt_reg, idle_cnt_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [2:0]       run_len_reg, run_len_next, run_len_upd;
    logic             run_val_reg, run_val_next;
    logic [WIDTH-1:0] shift_data_reg, shift_data_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             rx_ready_reg, rx_ready_next;
    logic             rx_error_reg, rx_error_next;
`ifdef CAN_RX_CRC15_EN
    logic [14:0]      crc_reg, crc_next, crc_rx_reg, crc_rx_next;
`endif
    logic             sample, fall_edge, busy, bit_in;
    logic             field_last, field_full, frame_err, frame_ok;

`ifdef CAN_RX_CRC15_EN
    // CAN CRC-15 (poly 0x4599), one bit per call, MSB-first feedback
    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[14];
        crc15_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction
`endif

    assign bit_in      = can_sync_reg;
    assign sample      = (qc_reg == QW'(SP));
    assign fall_edge   = can_prev_reg & ~can_sync_reg;
    assign busy        = (state_reg != WAIT_IDLE) && (state_reg != IDLE);
    assign run_len_upd = (bit_in == run_val_reg) ? run_len_reg + 3'd1 : 3'd1;

    assign bus.DOUT     = dout_reg;
    assign bus.rx_ready = rx_ready_reg;
    assign bus.rx_error = rx_error_reg;
    assign bus.busy     = busy;

    // Two-flop synchroniser for the asynchronous bus line, plus edge history
    always_ff @(posedge GCLK or posedge RES) begin
        if (RES) begin
            can_meta_reg <= 1'b1;
            can_sync_reg <= 1'b1;
            can_prev_reg <= 1'b1;
        end else begin
            can_meta_reg <= bus.CAN;
            can_sync_reg <= can_meta_reg;
            can_prev_reg <= can_sync_reg;
        end
    end

    // Decoder state register
    always_ff @(posedge GCLK or posedge RES) begin
        if (RES) begin
            qc_reg         <= '0;
            state_reg      <= WAIT_IDLE;
            idle_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            run_len_reg    <= '0;
            run_val_reg    <= 1'b0;
            shift_data_reg <= '0;
            dout_reg       <= '0;
            rx_ready_reg   <= 1'b0;
            rx_error_reg   <= 1'b0;
`ifdef CAN_RX_CRC15_EN
            crc_reg        <= '0;
            crc_rx_reg     <= '0;
`endif
        end else begin
            qc_reg         <= qc_next;
            state_reg      <= state_next;
            idle_cnt_reg   <= idle_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            run_len_reg    <= run_len_next;
            run_val_reg    <= run_val_next;
            shift_data_reg <= shift_data_next;
            dout_reg       <= dout_next;
            rx_ready_reg   <= rx_ready_next;
            rx_error_reg   <= rx_error_next;
`ifdef CAN_RX_CRC15_EN
            crc_reg        <= crc_next;
            crc_rx_reg     <= crc_rx_next;
`endif
        end
    end

    // Bit timing, destuffing and frame sequencing
    always_comb begin
        state_next      = state_reg;
        idle_cnt_next   = idle_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        run_len_next    = run_len_reg;
        run_val_next    = run_val_reg;
        shift_data_next = shift_data_reg;
        dout_next       = dout_reg;
        rx_ready_next   = 1'b0;
        rx_error_next   = 1'b0;
        frame_err       = 1'b0;
        frame_ok        = 1'b0;
`ifdef CAN_RX_CRC15_EN
        crc_next        = crc_reg;
        crc_rx_next     = crc_rx_reg;
        field_next      = (state_reg == DATA) ? CRC : EOF;
`else
        field_next      = EOF;
`endif
        field_last = (bit_cnt_reg == BW'(WIDTH - 1));
        field_full = (bit_cnt_reg == BW'(WIDTH));
`ifdef CAN_RX_CRC15_EN
        if (state_reg == CRC) begin
            field_last = (bit_cnt_reg == BW'(14));
            field_full = (bit_cnt_reg == BW'(15));
        end
`endif

        // Hard sync in IDLE, resync on any falling edge inside a frame
        // except in the sample cycle itself; otherwise free-run and wrap.
        if (fall_edge && ((state_reg == IDLE) || (busy && !sample)))
            qc_next = '0;
        else if (qc_reg == QW'(QUANTA - 1))
            qc_next = '0;
        else
            qc_next = qc_reg + QW'(1);

        case (state_reg)
            WAIT_IDLE: if (sample) begin
                if (!bit_in) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt_reg == IW'(IDLE_BITS - 1)) begin
                    idle_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt_reg + IW'(1);
                end
            end
            IDLE: if (fall_edge) begin
                state_next   = SOF;
                bit_cnt_next = '0;
`ifdef CAN_RX_CRC15_EN
                crc_next     = '0;
`endif
            end
            SOF: if (sample) begin
                if (bit_in) begin
                    // too short to be a start bit: treat as a glitch
                    state_next    = WAIT_IDLE;
                    idle_cnt_next = '0;
                end else begin
                    state_next   = DATA;
                    run_len_next = 3'd1;
                    run_val_next = 1'b0;
`ifdef CAN_RX_CRC15_EN
                    crc_next     = crc15_step(crc_reg, 1'b0);
`endif
                end
            end
            EOF: if (sample) begin
                if (!bit_in) begin
                    frame_err = 1'b1;
                end else if (bit_cnt_reg == BW'(6)) begin
                    frame_ok = 1'b1;
`ifdef CAN_RX_CRC15_EN
                    if (crc_rx_reg != crc_reg)
                        frame_ok = 1'b0;
`endif
                    if (frame_ok) begin
                        dout_next     = shift_data_reg;
                        rx_ready_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + BW'(1);
                end
            end
            default: if (sample) begin
                // stuffed fields: DATA (and CRC when enabled)
                if (run_len_reg == 3'd5) begin
                    if (bit_in == run_val_reg) begin
                        frame_err = 1'b1;
                    end else begin
                        run_len_next = 3'd1;
                        run_val_next = bit_in;
                        if (field_full) begin
                            bit_cnt_next = '0;
                            state_next   = field_next;
                        end
                    end
                end else begin
                    if (state_reg == DATA) begin
                        shift_data_next = {shift_data_reg[WIDTH-2:0], bit_in};
`ifdef CAN_RX_CRC15_EN
                        crc_next = crc15_step(crc_reg, bit_in);
                    end else begin
                        crc_rx_next = {crc_rx_reg[13:0], bit_in};
`endif
                    end
                    run_len_next = run_len_upd;
                    run_val_next = bit_in;
                    // a run closing on the last bit waits here for its stuff bit
                    if (field_last && (run_len_upd != 3'd5)) begin
                        bit_cnt_next = '0;
                        state_next   = field_next;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end
            end
        endcase

        if (frame_err) begin
            rx_error_next = 1'b1;
            state_next    = WAIT_IDLE;
            idle_cnt_next = '0;
        end
    end
endmodule

// File: tb/tb_can_rx_frame.sv
// tb_can_rx_frame: directed frames for can_rx_frame with a scoreboard.
// Stimulus pushes the expected response; a negedge monitor pops and compares
// on every rx_ready / rx_error pulse. Build with CAN_RX_CRC15_EN to include
// the CRC field in generated frames and run the CRC cases.
module tb_can_rx_frame;
    localparam int WIDTH  = 128;
    localparam int QUANTA = 39;

    logic GCLK = 1'b0;
    logic RES  = 1'b1;

    can_rx_frame_if #(.WIDTH(WIDTH)) bus ();

    can_rx_frame #(
        .WIDTH(WIDTH), .QUANTA(QUANTA), .SP(30), .IDLE_BITS(11)
    ) dut (
        .GCLK(GCLK),
        .RES (RES),
        .bus (bus)
    );

    always #5 GCLK = ~GCLK;

    typedef struct {
        bit               is_err;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    bit               frame_q[$];
    int               corrupt_pos;
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] last_good;

    // Monitor: one line per received transaction, compared against the queue
    always @(negedge GCLK) begin
        if (bus.rx_ready || bus.rx_error) begin
            n_checks++;
            if (bus.rx_ready && bus.rx_error) begin
                n_fail++;
                $display("FAIL strobes_exclusive: rx_ready=1 rx_error=1, required at most one high");
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: rx_ready=%0b rx_error=%0b, required no pulse", bus.rx_ready, bus.rx_error);
            end else begin
                mon_e = exp_q.pop_front();
                $display("rx %s DOUT=%h", bus.rx_ready ? "ready" : "error", bus.DOUT);
                if (bus.rx_error !== mon_e.is_err) begin
                    n_fail++;
                    $display("FAIL pulse_kind: rx_error=%0b, required %0b", bus.rx_error, mon_e.is_err);
                end
                n_checks++;
                if (bus.DOUT !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL dout_value: DOUT=%h, required %h", bus.DOUT, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

`ifdef CAN_RX_CRC15_EN
    function automatic logic [14:0] crc15_model(input bit bits[$]);
        logic [14:0] c;
        bit          fb;
        c = '0;
        foreach (bits[i]) begin
            fb = bits[i] ^ c[14];
            c  = {c[13:0], 1'b0};
            if (fb) c = c ^ 15'h4599;
        end
        return c;
    endfunction
`endif

    // Frame generator: SOF, payload MSB first, optional CRC, stuffing, EOF.
    // corrupt_stuff selects a stuff bit to replace by a 6th equal bit (-1: none).
    task automatic build_frame(input logic [WIDTH-1:0] payload, input int corrupt_stuff, input bit flip_crc0);
        bit raw[$];
        int run;
        bit rv;
        int ns;
`ifdef CAN_RX_CRC15_EN
        logic [14:0] crc;
`endif
        frame_q.delete();
        corrupt_pos = -1;
        raw.push_back(1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) raw.push_back(payload[i]);
`ifdef CAN_RX_CRC15_EN
        crc = crc15_model(raw);
        if (flip_crc0) crc[0] = ~crc[0];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
`else
        if (flip_crc0) $display("note: no CRC field in this build, flip request ignored");
`endif
        run = 0;
        rv  = 1'b1;
        ns  = 0;
        foreach (raw[i]) begin
            frame_q.push_back(raw[i]);
            if (run > 0 && raw[i] == rv) run++;
            else begin
                run = 1;
                rv  = raw[i];
            end
            if (run == 5) begin
                if (ns == corrupt_stuff) begin
                    corrupt_pos = frame_q.size();
                    frame_q.push_back(rv);
                end else begin
                    frame_q.push_back(~rv);
                end
                ns++;
                rv  = ~rv;
                run = 1;
            end
        end
        for (int i = 0; i < 7; i++) frame_q.push_back(1'b1);
    endtask

    task automatic send_bits(input int count, input int bit_t);
        for (int i = 0; i < count && i < frame_q.size(); i++) begin
            bus.CAN = frame_q[i];
            repeat (bit_t) @(negedge GCLK);
        end
        bus.CAN = 1'b1;
    endtask

    task automatic send_idle(input int nbits, input int bit_t);
        bus.CAN = 1'b1;
        repeat (nbits * bit_t) @(negedge GCLK);
    endtask

    task automatic expect_ok(input logic [WIDTH-1:0] payload);
        exp_t e;
        e.is_err  = 1'b0;
        e.data    = payload;
        last_good = payload;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = last_good;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 6 * QUANTA) begin
            @(negedge GCLK);
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic good_frame(input logic [WIDTH-1:0] payload, input int bit_t, input string name);
        build_frame(payload, -1, 1'b0);
        expect_ok(payload);
        send_idle(13, bit_t);
        send_bits(frame_q.size(), bit_t);
        drain(name);
    endtask

    logic [WIDTH-1:0] p_msg, p_zero, p_ones, p_alt, p_mix, p_b;

    initial begin
        p_msg  = "DIN1 -> DOUT2";
        p_zero = '0;
        p_ones = '1;
        p_alt  = {(WIDTH/4){4'hA}};
        p_mix  = 128'h0123456789ABCDEF_FEDCBA9876543210;
        p_b    = 128'hC0FFEE00_DEADBEEF_12345678_9ABCDEF0;
        last_good = '0;
        bus.CAN = 1'b1;

        // T1: reset held while the bus toggles
        RES = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge GCLK);
            bus.CAN = ~bus.CAN;
        end
        check("t1_dout_reset", bus.DOUT, '0);
        check("t1_rx_ready_reset", WIDTH'(bus.rx_ready), '0);
        check("t1_rx_error_reset", WIDTH'(bus.rx_error), '0);
        check("t1_busy_reset", WIDTH'(bus.busy), '0);
        bus.CAN = 1'b1;
        RES = 1'b0;
        repeat (5) @(negedge GCLK);
        check("t1_busy_after_release", WIDTH'(bus.busy), '0);

        // T2: good frame carrying the text payload
        good_frame(p_msg, QUANTA, "t2_good");
        check("t2_dout", bus.DOUT, p_msg);

        // T3: all-zero and all-one payloads, then a missing stuff bit
        good_frame(p_zero, QUANTA, "t3_zeros");
        good_frame(p_ones, QUANTA, "t3_ones");
        build_frame(p_zero, 0, 1'b0);
        expect_err();
        send_idle(13, QUANTA);
        send_bits(corrupt_pos + 2, QUANTA);
        drain("t3_stuff_err");
        check("t3_dout_kept", bus.DOUT, p_ones);

        // T4: short and long bit times, then a short dominant glitch
        good_frame(p_alt, QUANTA - 1, "t4_bit38");
        good_frame(p_mix, QUANTA + 1, "t4_bit40");
        send_idle(13, QUANTA);
        bus.CAN = 1'b0;
        repeat (3) @(negedge GCLK);
        bus.CAN = 1'b1;
        repeat (5) @(negedge GCLK);
        check("t4_glitch_busy_set", WIDTH'(bus.busy), WIDTH'(1));
        repeat (36) @(negedge GCLK);
        check("t4_glitch_busy_drop", WIDTH'(bus.busy), '0);
        check("t4_glitch_dout_kept", bus.DOUT, p_mix);

        // T5: dominant EOF bit 4, then reset in the middle of DATA
        build_frame(p_b, -1, 1'b0);
        frame_q[frame_q.size() - 4] = 1'b0;
        expect_err();
        send_idle(13, QUANTA);
        send_bits(frame_q.size(), QUANTA);
        drain("t5_form_err");
        build_frame(p_b, -1, 1'b0);
        send_idle(13, QUANTA);
        send_bits(60, QUANTA);
        RES = 1'b1;
        repeat (3) @(negedge GCLK);
        check("t5_dout_after_res", bus.DOUT, '0);
        check("t5_busy_after_res", WIDTH'(bus.busy), '0);
        RES = 1'b0;
        last_good = '0;
        good_frame(p_b, QUANTA, "t5_after_res");
        check("t5_dout_final", bus.DOUT, p_b);

`ifdef CAN_RX_CRC15_EN
        // T6: correct CRC, then CRC bit 0 flipped
        good_frame(p_msg, QUANTA, "t6_crc_ok");
        build_frame(p_mix, -1, 1'b1);
        expect_err();
        send_idle(13, QUANTA);
        send_bits(frame_q.size(), QUANTA);
        drain("t6_crc_err");
        check("t6_dout_kept", bus.DOUT, p_msg);
`endif

        send_idle(3, QUANTA);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
